// File: rtl/moore_seq_pkg.sv
// Shared types and constants for the scheduled phase sequencer.
package moore_seq_pkg;

    localparam int unsigned DW_DEF    = 4;
    localparam int unsigned NPH_FIXED = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } ctrl_e;

    localparam logic [1:0] PH0 = 2'd0;
    localparam logic [1:0] PH1 = 2'd1;
    localparam logic [1:0] PH2 = 2'd2;
    localparam logic [1:0] PH3 = 2'd3;

endpackage

// File: rtl/dwell_counter.sv
// Loadable down-counter that times one phase; saturates at zero.
module dwell_counter
    import moore_seq_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          en,
    input  logic [DW-1:0] load_val,
    output logic          zero_c
);

    logic [DW-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - DW'(1);
        end
    end

    assign zero_c = (count_q == '0);

endmodule

// File: rtl/moore_phase_sequencer.sv
// Steps a 2-bit phase code 0..3 with a per-phase dwell, plus start/stop/hold
// control, single-shot or looping operation and status pulses.
module moore_phase_sequencer
    import moore_seq_pkg::*;
#(
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned NPH = NPH_FIXED
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              hold,
    input  logic              loop_en,
    input  logic [NPH*DW-1:0] dwell_cfg,
    output logic [1:0]        out_state,
    output logic              busy,
    output logic              phase_tick,
    output logic              seq_done
);

    if (NPH != 4) begin : g_nph_check
        $error("moore_phase_sequencer: NPH must be 4 to match the 2-bit phase code");
    end

    ctrl_e         state_q, state_d;
    logic [1:0]    phase_d;
    logic [1:0]    phase_nxt;
    logic          busy_d, tick_d, done_d;
    logic          shadow_load;
    logic          cnt_load, cnt_en, cnt_zero_c;
    logic [DW-1:0] cnt_val;
    logic [DW-1:0] shadow_q [NPH];

    assign phase_nxt = out_state + 2'd1;

    dwell_counter #(.DW(DW)) u_dwell_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_val),
        .zero_c   (cnt_zero_c)
    );

    // State, phase, pulse and shadow registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            out_state  <= PH0;
            busy       <= 1'b0;
            phase_tick <= 1'b0;
            seq_done   <= 1'b0;
            for (int k = 0; k < NPH; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            out_state  <= phase_d;
            busy       <= busy_d;
            phase_tick <= tick_d;
            seq_done   <= done_d;
            if (shadow_load) begin
                for (int k = 0; k < NPH; k++) begin
                    shadow_q[k] <= dwell_cfg[k*DW +: DW];
                end
            end
        end
    end

    // Next-state: stop beats expiry, expiry beats hold.
    always_comb begin
        state_d     = state_q;
        phase_d     = out_state;
        busy_d      = busy;
        tick_d      = 1'b0;
        done_d      = 1'b0;
        shadow_load = 1'b0;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        cnt_val     = dwell_cfg[DW-1:0];

        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d     = RUN;
                    phase_d     = PH0;
                    busy_d      = 1'b1;
                    shadow_load = 1'b1;
                    cnt_load    = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    phase_d = PH0;
                    busy_d  = 1'b0;
                end else if (cnt_zero_c) begin
                    if (out_state == PH3) begin
                        phase_d = PH0;
                        done_d  = 1'b1;
                        if (loop_en) begin
                            tick_d      = 1'b1;
                            shadow_load = 1'b1;
                            cnt_load    = 1'b1;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        phase_d  = phase_nxt;
                        tick_d   = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = shadow_q[phase_nxt];
                    end
                end else if (hold) begin
                    state_d = HOLD;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                    phase_d = PH0;
                    busy_d  = 1'b0;
                end else if (!hold) begin
                    // Release edge already counts, so a hold of N cycles adds exactly N.
                    state_d = RUN;
                    cnt_en  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = PH0;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule
